bram_sdp_rr_arbiter: RTL

Shares one simple-dual-port, byte-write-enabled block RAM between NUM_REQ write requesters on port A and NUM_REQ read requesters on port B.
- Each port has independent round-robin arbitration with valid/ready handshakes.
- Read data returns in issue order, tagged with the requester index, through a 2-entry response buffer with full backpressure.
- Sits directly in front of the BRAM macro; its port A/B outputs connect one-to-one to the RAM's ena/wea/addra/dina/enb/addrb/doutb.

---
 rtl/bram_sdp_rr_arbiter_if.sv | 49 ++++
 rtl/bram_sdp_rr_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bram_sdp_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_sdp_rr_arbiter_if
// Brief    : Requester, response and BRAM port bundle for bram_sdp_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface bram_sdp_rr_arbiter_if #(
   parameter int NUM_REQ           = 4,
   parameter int NUMBER_OF_COLUMNS = 8,
   parameter int COLUMN_WIDTH      = 16,
   parameter int DEPTH             = 128
);
   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int DATA_WIDTH = NUMBER_OF_COLUMNS * COLUMN_WIDTH;
   localparam int ID_WIDTH   = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]                   wr_valid;
   logic [NUM_REQ-1:0]                   wr_ready;
   logic [NUM_REQ*ADDR_WIDTH-1:0]        wr_addr;
   logic [NUM_REQ*NUMBER_OF_COLUMNS-1:0] wr_be;
   logic [NUM_REQ*DATA_WIDTH-1:0]        wr_data;
   logic [NUM_REQ-1:0]                   rd_valid;
   logic [NUM_REQ-1:0]                   rd_ready;
   logic [NUM_REQ*ADDR_WIDTH-1:0]        rd_addr;
   logic                                 rsp_valid;
   logic                                 rsp_ready;
   logic [ID_WIDTH-1:0]                  rsp_id;
   logic [DATA_WIDTH-1:0]                rsp_data;
   logic                                 ena;
   logic [NUMBER_OF_COLUMNS-1:0]         wea;
   logic [ADDR_WIDTH-1:0]                addra;
   logic [DATA_WIDTH-1:0]                dina;
   logic                                 enb;
   logic [ADDR_WIDTH-1:0]                addrb;
   logic [DATA_WIDTH-1:0]                doutb;

   modport slave (
      input  wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr, rsp_ready, doutb,
      output wr_ready, rd_ready, rsp_valid, rsp_id, rsp_data,
             ena, wea, addra, dina, enb, addrb
   );

   modport master (
      output wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr, rsp_ready, doutb,
      input  wr_ready, rd_ready, rsp_valid, rsp_id, rsp_data,
             ena, wea, addra, dina, enb, addrb
   );
endinterface
`default_nettype wire

// File: rtl/bram_sdp_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_sdp_rr_arbiter
// Brief    : Round-robin write/read arbitration in front of a simple-dual-port
//            byte-write BRAM, with an in-order 2-entry tagged response buffer.
// Revision : 1.0 - initial release
// ============================================================================
module bram_sdp_rr_arbiter #(
   parameter int NUM_REQ           = 4,
   parameter int NUMBER_OF_COLUMNS = 8,
   parameter int COLUMN_WIDTH      = 16,
   parameter int DEPTH             = 128
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bram_sdp_rr_arbiter_if.slave bus
);
   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int DATA_WIDTH = NUMBER_OF_COLUMNS * COLUMN_WIDTH;
   localparam int ID_WIDTH   = $clog2(NUM_REQ);

   localparam logic [ID_WIDTH:0]   c_num_req  = (ID_WIDTH+1)'(NUM_REQ);
   localparam logic [ID_WIDTH-1:0] c_last_req = ID_WIDTH'(NUM_REQ - 1);

   // Returns {found, index} of the first request at or after ptr, wrapping.
   function automatic logic [ID_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0]  req,
                                                 input logic [ID_WIDTH-1:0] ptr);
      logic [ID_WIDTH:0] idx;
      logic [ID_WIDTH:0] pick;
      pick = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, ptr} + (ID_WIDTH+1)'(k);
         if (idx >= c_num_req) idx = idx - c_num_req;
         if (req[idx[ID_WIDTH-1:0]]) pick = {1'b1, idx[ID_WIDTH-1:0]};
      end
      return pick;
   endfunction

   function automatic logic [ID_WIDTH-1:0] rr_next(input logic [ID_WIDTH-1:0] win);
      return (win == c_last_req) ? '0 : win + ID_WIDTH'(1);
   endfunction

   logic [ID_WIDTH-1:0]   r_wr_ptr;
   logic [ID_WIDTH-1:0]   r_rd_ptr;
   logic                  r_inflight;
   logic [ID_WIDTH-1:0]   r_inflight_id;
   logic [1:0]            r_count;
   logic [ID_WIDTH-1:0]   r_buf_id   [2];
   logic [DATA_WIDTH-1:0] r_buf_data [2];

   logic [ID_WIDTH:0]     w_wr_pick;
   logic [ID_WIDTH:0]     w_rd_pick;
   logic [ID_WIDTH-1:0]   w_wr_win;
   logic [ID_WIDTH-1:0]   w_rd_win;
   logic                  w_wr_grant;
   logic                  w_rd_grant;
   logic                  w_rsp_valid;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_credit;
   logic [2:0]            w_cnt;
   logic [1:0]            w_base;

   assign w_wr_pick  = rr_pick(bus.wr_valid, r_wr_ptr);
   assign w_wr_win   = w_wr_pick[ID_WIDTH-1:0];
   assign w_wr_grant = w_wr_pick[ID_WIDTH] & rst_n;

   // Credit counts both buffered responses and the read still inside the RAM.
   assign w_rsp_valid = (r_count != 2'd0);
   assign w_pop       = w_rsp_valid & bus.rsp_ready;
   assign w_push      = r_inflight;
   assign w_cnt       = {1'b0, r_count} + {2'b00, r_inflight};
   assign w_credit    = (w_cnt - {2'b00, w_pop}) < 3'd2;
   assign w_base      = r_count - {1'b0, w_pop};

   assign w_rd_pick  = rr_pick(bus.rd_valid, r_rd_ptr);
   assign w_rd_win   = w_rd_pick[ID_WIDTH-1:0];
   assign w_rd_grant = w_rd_pick[ID_WIDTH] & w_credit & rst_n;

   always_comb begin
      bus.wr_ready           = '0;
      bus.rd_ready           = '0;
      bus.wr_ready[w_wr_win] = w_wr_grant;
      bus.rd_ready[w_rd_win] = w_rd_grant;
   end

   assign bus.ena   = w_wr_grant;
   assign bus.wea   = w_wr_grant ? bus.wr_be[w_wr_win*NUMBER_OF_COLUMNS +: NUMBER_OF_COLUMNS] : '0;
   assign bus.addra = bus.wr_addr[w_wr_win*ADDR_WIDTH +: ADDR_WIDTH];
   assign bus.dina  = bus.wr_data[w_wr_win*DATA_WIDTH +: DATA_WIDTH];
   assign bus.enb   = w_rd_grant;
   assign bus.addrb = bus.rd_addr[w_rd_win*ADDR_WIDTH +: ADDR_WIDTH];

   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_id    = r_buf_id[0];
   assign bus.rsp_data  = r_buf_data[0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_inflight    <= 1'b0;
         r_inflight_id <= '0;
         r_count       <= '0;
         r_buf_id[0]   <= '0;
         r_buf_id[1]   <= '0;
      end else begin
         if (w_wr_grant) r_wr_ptr <= rr_next(w_wr_win);
         if (w_rd_grant) begin
            r_rd_ptr      <= rr_next(w_rd_win);
            r_inflight_id <= w_rd_win;
         end
         r_inflight <= w_rd_grant;
         // Head shifts out on pop; the arriving word lands behind what remains.
         if (w_pop)  r_buf_id[0]         <= r_buf_id[1];
         if (w_push) r_buf_id[w_base[0]] <= r_inflight_id;
         r_count <= w_base + {1'b0, w_push};
      end
   end

   always_ff @(posedge clk) begin
      if (w_pop)           r_buf_data[0]         <= r_buf_data[1];
      if (w_push && rst_n) r_buf_data[w_base[0]] <= bus.doutb;
   end
endmodule
`default_nettype wire
